// File: rtl/gray_ptr_fifo_ctrl_if.sv
// Handshake/RAM/status bundle for gray_ptr_fifo_ctrl.
// GRAY_FIFO_ALMOST_EN adds the almost_full/almost_empty signals.
interface gray_ptr_fifo_ctrl_if #(
  parameter int unsigned ADDRWIDTH = 4
);
  localparam int unsigned PW = ADDRWIDTH + 1;

  logic                 clr;
  logic                 wr_valid;
  logic                 wr_ready;
  logic                 rd_valid;
  logic                 rd_ready;
  logic                 ram_we;
  logic [ADDRWIDTH-1:0] ram_waddr;
  logic [ADDRWIDTH-1:0] ram_raddr;
  logic [PW-1:0]        wr_ptr_gray;
  logic [PW-1:0]        rd_ptr_gray;
  logic [PW-1:0]        count;
  logic                 full;
  logic                 empty;
`ifdef GRAY_FIFO_ALMOST_EN
  logic                 almost_full;
  logic                 almost_empty;

  modport master (
    output clr, wr_valid, rd_ready,
    input  wr_ready, rd_valid, ram_we, ram_waddr, ram_raddr,
           wr_ptr_gray, rd_ptr_gray, count, full, empty,
           almost_full, almost_empty
  );
  modport slave (
    input  clr, wr_valid, rd_ready,
    output wr_ready, rd_valid, ram_we, ram_waddr, ram_raddr,
           wr_ptr_gray, rd_ptr_gray, count, full, empty,
           almost_full, almost_empty
  );
`else
  modport master (
    output clr, wr_valid, rd_ready,
    input  wr_ready, rd_valid, ram_we, ram_waddr, ram_raddr,
           wr_ptr_gray, rd_ptr_gray, count, full, empty
  );
  modport slave (
    input  clr, wr_valid, rd_ready,
    output wr_ready, rd_valid, ram_we, ram_waddr, ram_raddr,
           wr_ptr_gray, rd_ptr_gray, count, full, empty
  );
`endif
endinterface

// File: rtl/gray_ptr_fifo_ctrl.sv
// Single-clock FIFO controller for an external dual-port RAM with registered Gray pointer export.
// Optional almost_full/almost_empty flags are compiled in with GRAY_FIFO_ALMOST_EN.
module gray_ptr_fifo_ctrl #(
  parameter int unsigned ADDRWIDTH     = 4,
  parameter int unsigned ALMOST_THRESH = 2
) (
  input logic                 clk,
  input logic                 rst,
  gray_ptr_fifo_ctrl_if.slave bus
);
  localparam int unsigned PW    = ADDRWIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDRWIDTH;

  if ((ADDRWIDTH < 1) || (ALMOST_THRESH >= DEPTH)) begin : g_param_err
    $error("gray_ptr_fifo_ctrl: ADDRWIDTH must be >= 1 and ALMOST_THRESH < DEPTH");
  end

  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          wr_ready_q, wr_ready_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_fire_c;
  logic          rd_fire_c;
`ifdef GRAY_FIFO_ALMOST_EN
  logic          almost_full_q, almost_full_d;
  logic          almost_empty_q, almost_empty_d;
`endif

  // Fires only see registered readiness; clr and rst squash them so ram_we stays low.
  assign wr_fire_c = bus.wr_valid & wr_ready_q & ~bus.clr & ~rst;
  assign rd_fire_c = bus.rd_ready & rd_valid_q & ~bus.clr & ~rst;

  always_comb begin
    wr_bin_d   = wr_bin_q;
    rd_bin_d   = rd_bin_q;
    if (bus.clr) begin
      wr_bin_d = '0;
      rd_bin_d = '0;
    end else begin
      if (wr_fire_c) wr_bin_d = wr_bin_q + PW'(1);
      if (rd_fire_c) rd_bin_d = rd_bin_q + PW'(1);
    end
    wr_gray_d  = wr_bin_d ^ (wr_bin_d >> 1);
    rd_gray_d  = rd_bin_d ^ (rd_bin_d >> 1);
    count_d    = wr_bin_d - rd_bin_d;
    full_d     = (count_d == PW'(DEPTH));
    empty_d    = (count_d == '0);
    wr_ready_d = ~full_d;
    rd_valid_d = ~empty_d;
`ifdef GRAY_FIFO_ALMOST_EN
    almost_full_d  = (count_d >= PW'(DEPTH - ALMOST_THRESH));
    almost_empty_d = (count_d <= PW'(ALMOST_THRESH));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin_q   <= '0;
      rd_bin_q   <= '0;
      wr_gray_q  <= '0;
      rd_gray_q  <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      wr_ready_q <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      rd_bin_q   <= rd_bin_d;
      wr_gray_q  <= wr_gray_d;
      rd_gray_q  <= rd_gray_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef GRAY_FIFO_ALMOST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
`endif

  assign bus.wr_ready    = wr_ready_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.ram_we      = wr_fire_c;
  assign bus.ram_waddr   = wr_bin_q[ADDRWIDTH-1:0];
  assign bus.ram_raddr   = rd_bin_q[ADDRWIDTH-1:0];
  assign bus.wr_ptr_gray = wr_gray_q;
  assign bus.rd_ptr_gray = rd_gray_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
endmodule

// File: tb/tb_gray_ptr_fifo_ctrl.sv
// Self-checking bench for gray_ptr_fifo_ctrl (ADDRWIDTH=4) with a RAM model and data scoreboard.
// Almost-flag checks are compiled in with GRAY_FIFO_ALMOST_EN.
module tb_gray_ptr_fifo_ctrl;
  localparam int unsigned AW = 4;

  logic clk;
  logic rst;

  gray_ptr_fifo_ctrl_if #(.ADDRWIDTH(AW)) bus ();

  gray_ptr_fifo_ctrl #(.ADDRWIDTH(AW), .ALMOST_THRESH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [16];
  logic [7:0] wdata;
  logic [7:0] sb [$];

  always @(posedge clk) if (bus.ram_we) mem[bus.ram_waddr] <= wdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] m_wr, m_rd;
  int         wrap_seen;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    logic [4:0] g;
    g[4] = b[4];
    for (int i = 0; i < 4; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check combinational RAM side, then registered state after the edge.
  task automatic cycle(input logic wv, input logic rv, input logic cl, input logic rs);
    int         m_cnt;
    logic       wf, rf;
    logic [4:0] pwg, prg;
    @(negedge clk);
    bus.wr_valid = wv;
    bus.rd_ready = rv;
    bus.clr      = cl;
    rst          = rs;
    m_cnt = int'(5'(m_wr - m_rd));
    wf = wv && (m_cnt != 16) && !cl && !rs;
    rf = rv && (m_cnt != 0) && !cl && !rs;
    pwg = bus.wr_ptr_gray;
    prg = bus.rd_ptr_gray;
    #1;
    chk("ram_we", 32'(bus.ram_we), 32'(wf));
    if (wf) begin
      chk("ram_waddr", 32'(bus.ram_waddr), 32'(m_wr[3:0]));
      sb.push_back(wdata);
    end
    if (rf) begin
      logic [7:0] exp_d;
      chk("ram_raddr", 32'(bus.ram_raddr), 32'(m_rd[3:0]));
      exp_d = sb.pop_front();
      chk("rd_data", 32'(mem[bus.ram_raddr]), 32'(exp_d));
    end
    @(posedge clk);
    #1;
    if (rs || cl) begin
      m_wr = '0;
      m_rd = '0;
      sb.delete();
    end else begin
      if (wf) m_wr = m_wr + 5'd1;
      if (rf) m_rd = m_rd + 5'd1;
    end
    if (wf) wdata = wdata + 8'd1;
    m_cnt = int'(5'(m_wr - m_rd));
    chk("count", 32'(bus.count), 32'(m_cnt));
    chk("full", 32'(bus.full), 32'(m_cnt == 16));
    chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
    chk("wr_ready", 32'(bus.wr_ready), 32'(m_cnt != 16));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_cnt != 0));
    chk("wr_gray", 32'(bus.wr_ptr_gray), 32'(to_gray(m_wr)));
    chk("rd_gray", 32'(bus.rd_ptr_gray), 32'(to_gray(m_rd)));
    if (wf && !rs && !cl) chk("wr_gray_step", 32'($countones(pwg ^ bus.wr_ptr_gray)), 32'd1);
    if (rf && !rs && !cl) begin
      chk("rd_gray_step", 32'($countones(prg ^ bus.rd_ptr_gray)), 32'd1);
      if (prg == 5'b10000) begin
        wrap_seen++;
        chk("rd_gray_wrap", 32'(bus.rd_ptr_gray), 32'd0);
      end
    end
`ifdef GRAY_FIFO_ALMOST_EN
    chk("almost_full", 32'(bus.almost_full), 32'(m_cnt >= 14));
    chk("almost_empty", 32'(bus.almost_empty), 32'(m_cnt <= 2));
`endif
  endtask

  typedef struct {
    string      name;
    logic       wv, rv, cl, rs;
    int         n;
    int         exp_cnt;
    logic [4:0] exp_wg, exp_rg;
  } vec_t;

  vec_t vecs [15];

  initial begin
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    bus.clr      = 1'b0;
    rst          = 1'b1;
    wdata        = 8'h40;
    m_wr         = '0;
    m_rd         = '0;
    wrap_seen    = 0;

    vecs[0]  = '{"reset",        1'b0, 1'b0, 1'b0, 1'b1,  2,  0, 5'b00000, 5'b00000};
    vecs[1]  = '{"fill",         1'b1, 1'b0, 1'b0, 1'b0, 16, 16, 5'b11000, 5'b00000};
    vecs[2]  = '{"write_full",   1'b1, 1'b0, 1'b0, 1'b0,  1, 16, 5'b11000, 5'b00000};
    vecs[3]  = '{"drain",        1'b0, 1'b1, 1'b0, 1'b0, 16,  0, 5'b11000, 5'b11000};
    vecs[4]  = '{"read_empty",   1'b0, 1'b1, 1'b0, 1'b0,  1,  0, 5'b11000, 5'b11000};
    vecs[5]  = '{"to_five",      1'b1, 1'b0, 1'b0, 1'b0,  5,  5, 5'b11111, 5'b11000};
    vecs[6]  = '{"simul",        1'b1, 1'b1, 1'b0, 1'b0, 10,  5, 5'b10000, 5'b10111};
    vecs[7]  = '{"wrap40",       1'b1, 1'b1, 1'b0, 1'b0, 40,  5, 5'b00100, 5'b00011};
    vecs[8]  = '{"to_nine",      1'b1, 1'b0, 1'b0, 1'b0,  4,  9, 5'b01110, 5'b00011};
    vecs[9]  = '{"clr_with_wr",  1'b1, 1'b0, 1'b1, 1'b0,  1,  0, 5'b00000, 5'b00000};
    vecs[10] = '{"refill_nine",  1'b1, 1'b0, 1'b0, 1'b0,  9,  9, 5'b01101, 5'b00000};
    vecs[11] = '{"rst_with_wr",  1'b1, 1'b0, 1'b0, 1'b1,  1,  0, 5'b00000, 5'b00000};
    vecs[12] = '{"fill_again",   1'b1, 1'b0, 1'b0, 1'b0, 16, 16, 5'b11000, 5'b00000};
    vecs[13] = '{"full_wr_rd",   1'b1, 1'b1, 1'b0, 1'b0,  1, 15, 5'b11000, 5'b00001};
    vecs[14] = '{"wr_after_rd",  1'b1, 1'b0, 1'b0, 1'b0,  1, 16, 5'b11001, 5'b00001};

    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].n; k++) cycle(vecs[v].wv, vecs[v].rv, vecs[v].cl, vecs[v].rs);
      chk({vecs[v].name, "_count"}, 32'(bus.count), 32'(vecs[v].exp_cnt));
      chk({vecs[v].name, "_wgray"}, 32'(bus.wr_ptr_gray), 32'(vecs[v].exp_wg));
      chk({vecs[v].name, "_rgray"}, 32'(bus.rd_ptr_gray), 32'(vecs[v].exp_rg));
    end

    // Drain to empty, then single-word latency: readable exactly one cycle after its write.
    for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("drain2_empty", 32'(bus.empty), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("lat_rd_valid", 32'(bus.rd_valid), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lat_empty_again", 32'(bus.empty), 32'd1);

    // Almost-flag boundaries walking count 0..3 and up to 14.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef GRAY_FIFO_ALMOST_EN
      if (c == 2)  chk("ae_at_2", 32'(bus.almost_empty), 32'd1);
      if (c == 3)  chk("ae_at_3", 32'(bus.almost_empty), 32'd0);
      if (c == 13) chk("af_at_13", 32'(bus.almost_full), 32'd0);
      if (c == 14) chk("af_at_14", 32'(bus.almost_full), 32'd1);
`endif
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    chk("gray_wrap_seen", 32'(wrap_seen > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gray_ptr_fifo_ctrl.md
Name: gray_ptr_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences an external dual-port RAM. It owns the write and read pointers, valid/ready handshakes, full/empty, occupancy and a synchronous flush. Both pointers are also exported as registered Gray code, one bit changing per step, so other clock domains can synchronise them safely. Binary-to-Gray encoding is done internally and registered.

Parameters:
- ADDRWIDTH, 4, RAM address width; FIFO depth DEPTH = 2**ADDRWIDTH; minimum 1.
- ALMOST_THRESH, 2, margin for the almost flags; used only when the optional feature is compiled in; must be < DEPTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous flush: empties the FIFO.
- wr_valid  input  1  producer has a word.
- wr_ready  output  1  controller accepts a write this cycle.
- rd_valid  output  1  RAM word at rd_addr is valid.
- rd_ready  input  1  consumer takes the word.
- ram_we  output  1  RAM write enable (= write fire).
- ram_waddr  output  ADDRWIDTH  RAM write address.
- ram_raddr  output  ADDRWIDTH  RAM read address (combinational-read RAM).
- wr_ptr_gray  output  ADDRWIDTH+1  registered Gray write pointer.
- rd_ptr_gray  output  ADDRWIDTH+1  registered Gray read pointer.
- count  output  ADDRWIDTH+1  occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Internal binary pointers wr_bin and rd_bin are ADDRWIDTH+1 bits and wrap modulo 2**(ADDRWIDTH+1).
- Reset (rst=1 at the clock edge): wr_bin = rd_bin = 0, both Gray outputs 0, count 0, empty 1, full 0, wr_ready 1, rd_valid 0, ram_we 0.
- rst has priority over clr, and clr has priority over any handshake.
- Handshake outputs:
  - wr_ready = !full; wr_fire = wr_valid & wr_ready.
  - rd_valid = !empty; rd_fire = rd_valid & rd_ready.
  - wr_ready and rd_valid depend only on registered state. No combinational path from wr_valid or rd_ready to them.
- RAM interface:
  - ram_we = wr_fire.
  - ram_waddr = wr_bin[ADDRWIDTH-1:0].
  - ram_raddr = rd_bin[ADDRWIDTH-1:0].
  - Write data is in the RAM one edge after ram_we. Read data is valid in the same cycle as rd_valid.
- On a wr_fire edge: wr_bin += 1 and wr_ptr_gray <= next_wr ^ (next_wr >> 1), updated on the same edge. The read side mirrors this on rd_fire.
- Gray outputs are flop outputs, never combinational. Consecutive values differ in exactly one bit, including the wrap from max back to 0.
- count = wr_bin - rd_bin, computed modulo 2**(ADDRWIDTH+1) and registered. full and empty are registered.
- Simultaneous wr_fire and rd_fire: both pointers advance, count unchanged.
- Full: writes are blocked even if a read fires in the same cycle; wr_ready rises the cycle after the read.
- Empty: no read fires. There is no bypass; a written word becomes readable the cycle after its write.
- clr: next edge sets both pointers, both Gray outputs and count to 0, empty to 1, full to 0. Fires in that cycle are discarded and ram_we is forced to 0.
- Reset or clr mid-stream discards all stored words; RAM contents are not cleared.
- Latency: write-to-rd_valid is 1 cycle; read-to-wr_ready when full is 1 cycle.

Optional Feature:
Macro GRAY_FIFO_ALMOST_EN.
- Defined: adds registered outputs almost_full (count >= DEPTH-ALMOST_THRESH) and almost_empty (count <= ALMOST_THRESH). Reset and clr values: almost_full 0, almost_empty 1. Both update on the same edge as count.
- Undefined: the ports do not exist, and ALMOST_THRESH is ignored.

Test Plan:
- Fill (ADDRWIDTH=4): reset, then 16 consecutive writes with rd_ready=0. After the 16th edge: full=1, wr_ready=0, count=16, wr_ptr_gray=5'b11000. A 17th wr_valid gives ram_we=0.
- Drain: from full, hold rd_ready=1 for 16 cycles. ram_raddr steps 0..15 and data matches the write order. Then empty=1, rd_ptr_gray=5'b11000, count=0.
- Simultaneous: at count=5, drive wr_valid=rd_ready=1 for 10 cycles. count stays 5 and both Gray pointers advance 10 steps.
- Wrap: 40 write+read pairs. Every Gray step has Hamming distance 1, and the wrap goes from 5'b10000 (bin 31) to 5'b00000.
- Flush: at count=9, assert clr together with wr_valid=1 for one cycle. Next cycle count=0, empty=1, both Gray pointers 0, ram_we was 0. rst=1 mid-stream gives the same result.
- Optional (macro defined, ALMOST_THRESH=2): almost_empty is 1 at count 0..2 and 0 at 3. almost_full rises at count 14.
